// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the PIC control logic.
//   pic_state_t     - interrupt-service state machine encoding
//   OCW2 commands   - decoded from ocw2[7:5] (R, SL, EOI)
//   SPURIOUS_LEVEL  - level reported when INTA arrives with nothing to serve
//   prio_rank()     - distance of a level from the current highest priority
//   level_mask()    - one-hot mask for a 3-bit level
package pic_pkg;

    localparam int N_IR = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK1 = 2'd2,
        ACK2 = 2'd3
    } pic_state_t;

    localparam logic [2:0] NS_EOI       = 3'b001;
    localparam logic [2:0] S_EOI        = 3'b011;
    localparam logic [2:0] ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] ROT_S_EOI    = 3'b111;
    localparam logic [2:0] SET_PRIO     = 3'b110;
    localparam logic [2:0] ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] ROT_AEOI_CLR = 3'b000;

    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    // Rank 0 is the highest priority, i.e. level (prio_low + 1) mod 8.
    function automatic logic [2:0] prio_rank(input logic [2:0] level,
                                             input logic [2:0] prio_low);
        return level - prio_low - 3'd1;
    endfunction

    function automatic logic [7:0] level_mask(input logic [2:0] level);
        return 8'b0000_0001 << level;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: combinational rotating-priority encoder.
//   req_vec  in  8  candidate bits (request or in-service)
//   prio_low in  3  lowest-priority level; (prio_low+1) mod 8 is highest
//   valid    out 1  any bit of req_vec set
//   level    out 3  highest-priority set level (SPURIOUS_LEVEL when !valid)
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] req_vec,
    input  logic [2:0] prio_low,
    output logic       valid,
    output logic [2:0] level
);

    logic [2:0] idx;

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        valid = 1'b0;
        level = SPURIOUS_LEVEL;
        idx   = '0;
        for (int k = 7; k >= 0; k--) begin
            idx = prio_low + 3'd1 + 3'(k);
            if (req_vec[idx]) begin
                valid = 1'b1;
                level = idx;
            end
        end
    end

endmodule

// File: rtl/pic_control_logic.sv
// pic_control_logic: IRR/ISR bookkeeping, rotating priority resolution,
// INT generation and the two-pulse INTA vector handshake of an 8259-style PIC.
//   clk, rst_n      clock, asynchronous active-low reset
//   ir[7:0]         interrupt request lines
//   inta_n          CPU interrupt acknowledge (active low)
//   icw1_wr         re-initialise strobe; ltim selects level/edge trigger
//   vec_base[4:0]   vector base; aeoi enables automatic EOI
//   init_done       initialisation complete (IRR held clear until set)
//   imr[7:0]        interrupt mask (1 = masked)
//   ocw2_wr, ocw2   OCW2 command strobe and byte
//   int_o           interrupt request to the CPU
//   irr, isr        request / in-service registers for read-back
//   vec, vec_oe     vector byte and its bus-drive enable
module pic_control_logic
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir,
    input  logic       inta_n,
    input  logic       icw1_wr,
    input  logic       ltim,
    input  logic [4:0] vec_base,
    input  logic       aeoi,
    input  logic       init_done,
    input  logic [7:0] imr,
    input  logic       ocw2_wr,
    input  logic [7:0] ocw2,
    output logic       int_o,
    output logic [7:0] irr,
    output logic [7:0] isr,
    output logic [7:0] vec,
    output logic       vec_oe
);

    pic_state_t state, state_next;

    logic [7:0] ir_prev;
    logic       inta_d;
    logic [2:0] prio_low;
    logic       rot_aeoi;
    logic [2:0] win_lvl, win_lvl_next;
    logic       win_spur, win_spur_next;

    logic       int_next, vec_oe_next;
    logic [7:0] vec_next;
    logic [7:0] ack_set, aeoi_clr, eoi_clr, irr_next;
    logic       aeoi_rot;
    logic       prio_wr, rot_set, rot_clr;
    logic [2:0] prio_val;

    logic [7:0] req;
    logic       req_valid, isr_valid;
    logic [2:0] req_lvl, isr_lvl;
    logic       cond;
    logic       inta_fall, inta_rise;
    logic [2:0] ocw_cmd, ocw_lvl;
    logic       unused_ocw2;

    assign req         = irr & ~imr;
    assign ocw_cmd     = ocw2[7:5];
    assign ocw_lvl     = ocw2[2:0];
    assign unused_ocw2 = ^ocw2[4:3];

    pic_priority_resolver u_req_res (
        .req_vec  (req),
        .prio_low (prio_low),
        .valid    (req_valid),
        .level    (req_lvl)
    );

    pic_priority_resolver u_isr_res (
        .req_vec  (isr),
        .prio_low (prio_low),
        .valid    (isr_valid),
        .level    (isr_lvl)
    );

    // A request is worth raising INT only if it outranks everything in service.
    assign cond = req_valid &&
                  (!isr_valid || (prio_rank(req_lvl, prio_low) < prio_rank(isr_lvl, prio_low)));

    assign inta_fall = inta_d & ~inta_n;
    assign inta_rise = ~inta_d & inta_n;

    // INTA handshake: int_o stays high in REQ until the CPU's first INTA
    // falling edge, which freezes the winning level. The second falling edge
    // loads vec and raises vec_oe; vec is valid on the bus exactly while
    // vec_oe is high, and the following INTA rising edge drops vec_oe and
    // ends the cycle.
    always_comb begin
        state_next    = state;
        int_next      = int_o;
        vec_oe_next   = vec_oe;
        vec_next      = vec;
        win_lvl_next  = win_lvl;
        win_spur_next = win_spur;
        ack_set       = '0;
        aeoi_clr      = '0;
        aeoi_rot      = 1'b0;
        case (state)
            IDLE: begin
                if (inta_fall) begin
                    // Unsolicited acknowledge: answer with the spurious level.
                    win_lvl_next  = SPURIOUS_LEVEL;
                    win_spur_next = 1'b1;
                    state_next    = ACK1;
                end else if (cond) begin
                    int_next   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (inta_fall) begin
                    int_next   = 1'b0;
                    state_next = ACK1;
                    if (cond) begin
                        win_lvl_next  = req_lvl;
                        win_spur_next = 1'b0;
                        ack_set       = level_mask(req_lvl);
                    end else begin
                        win_lvl_next  = SPURIOUS_LEVEL;
                        win_spur_next = 1'b1;
                    end
                end else if (!cond) begin
                    int_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            ACK1: begin
                if (inta_fall) begin
                    vec_next    = {vec_base, win_lvl};
                    vec_oe_next = 1'b1;
                    state_next  = ACK2;
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    vec_oe_next = 1'b0;
                    state_next  = IDLE;
                    if (aeoi && !win_spur) begin
                        aeoi_clr = level_mask(win_lvl);
                        aeoi_rot = rot_aeoi;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // OCW2 decode. Non-specific forms act on the highest-priority ISR bit and
    // do nothing at all when ISR is empty.
    always_comb begin
        eoi_clr  = '0;
        prio_wr  = 1'b0;
        prio_val = prio_low;
        rot_set  = 1'b0;
        rot_clr  = 1'b0;
        if (ocw2_wr) begin
            case (ocw_cmd)
                NS_EOI: begin
                    if (isr_valid) eoi_clr = level_mask(isr_lvl);
                end
                S_EOI: eoi_clr = level_mask(ocw_lvl);
                ROT_NS_EOI: begin
                    if (isr_valid) begin
                        eoi_clr  = level_mask(isr_lvl);
                        prio_wr  = 1'b1;
                        prio_val = isr_lvl;
                    end
                end
                ROT_S_EOI: begin
                    eoi_clr  = level_mask(ocw_lvl);
                    prio_wr  = 1'b1;
                    prio_val = ocw_lvl;
                end
                SET_PRIO: begin
                    prio_wr  = 1'b1;
                    prio_val = ocw_lvl;
                end
                ROT_AEOI_SET: rot_set = 1'b1;
                ROT_AEOI_CLR: rot_clr = 1'b1;
                default: ;
            endcase
        end
    end

    // Edge mode: a bit needs a fresh 0->1 to set and drops as soon as the line
    // goes low; acknowledge clears win over any set in the same cycle.
    always_comb begin
        irr_next = '0;
        if (init_done) begin
            if (ltim) irr_next = ir & ~ack_set;
            else      irr_next = (irr | (ir & ~ir_prev)) & ir & ~ack_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            int_o    <= 1'b0;
            irr      <= '0;
            isr      <= '0;
            vec      <= '0;
            vec_oe   <= 1'b0;
            prio_low <= 3'd7;
            rot_aeoi <= 1'b0;
            ir_prev  <= 8'hFF;
            win_lvl  <= SPURIOUS_LEVEL;
            win_spur <= 1'b1;
        end else if (icw1_wr) begin
            state    <= IDLE;
            int_o    <= 1'b0;
            irr      <= '0;
            isr      <= '0;
            vec      <= '0;
            vec_oe   <= 1'b0;
            prio_low <= 3'd7;
            rot_aeoi <= 1'b0;
            ir_prev  <= 8'hFF;
            win_lvl  <= SPURIOUS_LEVEL;
            win_spur <= 1'b1;
        end else begin
            state    <= state_next;
            int_o    <= int_next;
            irr      <= irr_next;
            // EOI clears apply before the acknowledge set, so set wins.
            isr      <= (isr & ~eoi_clr & ~aeoi_clr) | ack_set;
            vec      <= vec_next;
            vec_oe   <= vec_oe_next;
            ir_prev  <= ir;
            win_lvl  <= win_lvl_next;
            win_spur <= win_spur_next;
            if (aeoi_rot)     prio_low <= win_lvl;
            else if (prio_wr) prio_low <= prio_val;
            if (rot_set)      rot_aeoi <= 1'b1;
            else if (rot_clr) rot_aeoi <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inta_d <= 1'b1;
        else        inta_d <= inta_n;
    end

endmodule

// File: doc/pic_control_logic.md
Name: pic_control_logic

Overview:
Sequences interrupt service for the 8259-compatible PIC. Holds the IRR and ISR registers and does priority resolution with rotation. Drives INT to the CPU and runs the two-pulse INTA handshake that puts the vector on the data bus. It is fed by the read/write front end, which supplies ICW/OCW write strobes, the data byte and the IMR, and it returns IRR/ISR for CPU read-back.

Parameters:
- N_IR, 8, number of interrupt request lines (fixed 8; 3-bit level encoding)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ir  in  8  interrupt request lines, synchronous to clk
- inta_n  in  1  CPU interrupt acknowledge, active-low, synchronous to clk
- icw1_wr  in  1  one-cycle strobe: ICW1 written (re-initialise)
- ltim  in  1  ICW1 bit3: 1 = level-triggered, 0 = edge-triggered
- vec_base  in  5  ICW2[7:3] vector base
- aeoi  in  1  ICW4 bit1: automatic end of interrupt
- init_done  in  1  initialisation sequence complete
- imr  in  8  interrupt mask register (1 = masked)
- ocw2_wr  in  1  one-cycle strobe: OCW2 written
- ocw2  in  8  OCW2 byte: [7:5] command R/SL/EOI, [2:0] level L
- int_o  out  1  interrupt request to CPU
- irr  out  8  interrupt request register
- isr  out  8  in-service register
- vec  out  8  vector byte
- vec_oe  out  1  vec valid / drive data bus

Behaviour:
- Reset (rst_n low, async) and icw1_wr (sync, any state):
  - int_o=0, irr=0, isr=0, vec=0, vec_oe=0, state=IDLE.
  - lowest-priority pointer prio_low=7, so IR0 is highest.
  - rot_aeoi=0.
  - Edge history ir_prev=8'hFF, so any line already high must fall then rise again.
- IRR:
  - Edge mode: irr[i] is set on a sampled 0->1 of ir[i]. It clears when ir[i] is low, or in the cycle the bit is acknowledged; clear wins over set.
  - Level mode: irr[i] <= ir[i], cleared on acknowledge of that bit.
  - IRR is held at 0 while init_done=0.
- Priority:
  - Order is circular starting at level (prio_low+1) mod 8.
  - req = irr & ~imr.
  - The condition is met when the highest req level has strictly higher priority than the highest isr level, or isr=0.
- int_o: registered, asserted 1 cycle after the condition holds in IDLE. Deasserted on the first INTA falling edge.
- INTA edges: inta_n is registered. Fall = prev 1 & cur 0; rise = prev 0 & cur 1.
- State machine:
  - IDLE -> REQ when the condition holds, with int_o=1.
  - REQ -> IDLE if the condition drops before INTA; int_o=0.
  - REQ, on 1st fall: freeze the winning level W, set isr[W], clear irr[W], go to ACK1. If there is no valid request at that fall, W=7 (spurious) and isr is not set.
  - ACK1 -> ACK2 on 2nd fall. vec={vec_base,W} and vec_oe=1 from the next cycle while inta_n is low.
  - ACK2 -> IDLE on rise: vec_oe=0. If aeoi, clear isr[W] (non-spurious only), and set prio_low=W when rot_aeoi=1.
  - An INTA fall in IDLE is treated as a spurious 1st pulse: W=7, go to ACK1.
- OCW2 commands, decoded on ocw2_wr, with L=ocw2[2:0]:
  - 001 non-specific EOI: clear the highest-priority isr bit.
  - 011 specific EOI: clear isr[L].
  - 101 rotate on non-specific EOI: clear the highest isr bit J and set prio_low=J.
  - 111 rotate on specific EOI: clear isr[L] and set prio_low=L.
  - 110 set priority: prio_low=L.
  - 100 sets rot_aeoi; 000 clears it; 010 is a no-op.
  - A non-specific EOI with isr=0 is a no-op.
- Same-cycle events:
  - The EOI clear is applied first, then the acknowledge set. If both hit the same bit, set wins.
  - icw1_wr overrides everything else.

Decomposition:
- Package pic_pkg holds:
  - state enum {IDLE, REQ, ACK1, ACK2};
  - OCW2 command localparams (NS_EOI=3'b001, S_EOI=3'b011, ROT_NS_EOI=3'b101, ROT_S_EOI=3'b111, SET_PRIO=3'b110, ROT_AEOI_SET=3'b100, ROT_AEOI_CLR=3'b000);
  - SPURIOUS_LEVEL=3'd7.
- Sub-module pic_priority_resolver: combinational. Takes an 8-bit vector and prio_low and returns a valid flag plus the highest-priority 3-bit level. Instantiated twice, once for req and once for isr.

Test Plan:
- Reset, init_done=1, vec_base=5'h08, edge mode, imr=0. Raise ir[3] -> irr=8'h08, int_o=1 one cycle later. Two INTA pulses -> isr=8'h08, irr=0, vec=8'h43 with vec_oe=1 during the 2nd pulse only. Then OCW2=8'h20 -> isr=0.
- Nesting: IR5 in service, raise ir[6] -> int_o stays 0. Raise ir[2] -> int_o=1; after ack isr=8'h24.
- Rotation: OCW2=8'hC4 (set priority, L=4) -> IR5 highest. With ir[1] and ir[5] high, acknowledge -> vec low bits=5, isr=8'h20.
- AEOI with rot_aeoi: aeoi=1, OCW2=8'h80, ir[0] acknowledged -> isr returns to 0 on the 2nd INTA rise, and prio_low=0 so IR1 is highest.
- Spurious and masking: raise ir[4], drop it before INTA in edge mode -> int_o falls. Pulse INTA twice anyway -> vec low bits=7, isr=0. With imr=8'h10, ir[4] never raises int_o.
- Re-init mid-handshake: icw1_wr in ACK1 -> all outputs 0 next cycle. A held-high ir[2] does not re-request until it toggles low then high.
